// File: rtl/amm_regfile_bridge.sv
// Avalon-MM slave front-end for the byte-enabled CSR file: registered write strobe, timed reads.
// Define AMM_RF_BRIDGE_ERR_EN to add address range checking and the amm_response_o port.
module amm_regfile_bridge #(
  parameter int unsigned ADDR_W        = 7,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned BE_W          = (DATA_W + 7) / 8,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned CTRL_CNT      = 32,
  parameter int unsigned STAT_CNT      = 32,
  parameter int unsigned SEL_SR_BY_MSB = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] amm_address_i,
  input  logic              amm_read_i,
  input  logic              amm_write_i,
  input  logic [DATA_W-1:0] amm_writedata_i,
  input  logic [BE_W-1:0]   amm_byteenable_i,
  output logic              amm_waitrequest_o,
  output logic [DATA_W-1:0] amm_readdata_o,
  output logic              amm_readdatavalid_o,
  output logic              rf_wren_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic [BE_W-1:0]   rf_be_o,
`ifdef AMM_RF_BRIDGE_ERR_EN
  output logic [1:0]        amm_response_o,
`endif
  input  logic [DATA_W-1:0] rf_data_i
);

  typedef enum logic [1:0] {StInit, StIdle, StRdWait} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wait_q, wait_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              addr_ok;

`ifdef AMM_RF_BRIDGE_ERR_EN
  logic [1:0] resp_q, resp_d;

  // Same decode as the register file: MSB selects the status bank, or a flat range.
  always_comb begin
    if (SEL_SR_BY_MSB != 0) begin
      if (amm_address_i[ADDR_W-1]) addr_ok = 32'(amm_address_i[ADDR_W-2:0]) < STAT_CNT;
      else                         addr_ok = 32'(amm_address_i[ADDR_W-2:0]) < CTRL_CNT;
    end else begin
      addr_ok = 32'(amm_address_i) < (CTRL_CNT + STAT_CNT);
    end
  end
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
`ifdef AMM_RF_BRIDGE_ERR_EN
    resp_d   = 2'b00;
`endif
    unique case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        // Write wins when both strobes are set; the read is dropped.
        if (amm_write_i) begin
          addr_d  = amm_address_i;
          wdata_d = amm_writedata_i;
          be_d    = amm_byteenable_i;
          wren_d  = addr_ok;
        end else if (amm_read_i) begin
          addr_d  = amm_address_i;
          cnt_d   = 3'(RD_LAT);
          err_d   = !addr_ok;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (cnt_q == 3'd1) begin
          rvalid_d = 1'b1;
          rdata_d  = err_q ? '0 : rf_data_i;
`ifdef AMM_RF_BRIDGE_ERR_EN
          resp_d   = err_q ? 2'b10 : 2'b00;
`endif
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StInit;
    endcase
    wait_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wait_q   <= 1'b1;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef AMM_RF_BRIDGE_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) resp_q <= 2'b00;
    else       resp_q <= resp_d;
  end
  assign amm_response_o = resp_q;
`endif

  assign amm_waitrequest_o   = wait_q;
  assign amm_readdata_o      = rdata_q;
  assign amm_readdatavalid_o = rvalid_q;
  assign rf_wren_o           = wren_q;
  assign rf_addr_o           = addr_q;
  assign rf_data_o           = wdata_q;
  assign rf_be_o             = be_q;

endmodule

// File: doc/amm_regfile_bridge.md
Name: amm_regfile_bridge

Overview:
- Avalon-MM slave front-end that sits directly upstream of the byte-enabled control/status register file.
- Accepts Avalon-MM reads and writes from the HPS/interconnect and converts them into the register file's single-cycle write strobe and combinational read port.
- Registers all register-file-side outputs.
- Holds the read address stable for a programmable sampling latency, then returns data with readdatavalid.

Parameters:
- ADDR_W, 7: word address width, equal to the register file's ADDR_W.
- DATA_W, 32: data width.
- BE_W, ceil(DATA_W/8): byte-enable width.
- RD_LAT, 1: cycles between driving rf_addr_o and sampling rf_data_i. Range 1..7.
- CTRL_CNT, 32: control register count. Used for range checking only.
- STAT_CNT, 32: status register count. Used for range checking only.
- SEL_SR_BY_MSB, 1: address decode mode, matching the register file. Used for range checking only.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- amm_address_i  in  ADDR_W  word address
- amm_read_i  in  1  read request
- amm_write_i  in  1  write request
- amm_writedata_i  in  DATA_W  write data
- amm_byteenable_i  in  BE_W  byte enables
- amm_waitrequest_o  out  1  command not accepted this cycle
- amm_readdata_o  out  DATA_W  read data
- amm_readdatavalid_o  out  1  read data valid, one-cycle pulse
- rf_wren_o  out  1  register file write strobe
- rf_addr_o  out  ADDR_W  register file address
- rf_data_o  out  DATA_W  register file write data
- rf_be_o  out  BE_W  register file byte enables
- rf_data_i  in  DATA_W  register file read data (combinational from rf_addr_o)
- amm_response_o  out  2  response code; exists only when AMM_RF_BRIDGE_ERR_EN is defined

Behaviour:
- Reset values (held while rst_i=1):
  - amm_waitrequest_o=1.
  - amm_readdatavalid_o=0, amm_readdata_o=0.
  - rf_wren_o=0, rf_addr_o=0, rf_data_o=0, rf_be_o=0.
  - amm_response_o=0.
  - State=INIT.
- FSM states: INIT, IDLE, RD_WAIT.
- INIT:
  - Entered on reset.
  - Moves to IDLE on the first clock edge after rst_i deasserts.
  - amm_waitrequest_o=1.
- IDLE:
  - amm_waitrequest_o=0; a command present this cycle is accepted at the next edge E0.
  - Write accepted at E0:
    - rf_addr_o, rf_data_o and rf_be_o are loaded from the Avalon inputs.
    - rf_wren_o=1 for exactly the one cycle after E0.
    - State stays IDLE, so back-to-back writes sustain one per cycle.
  - Read accepted at E0:
    - rf_addr_o is loaded; rf_wren_o=0.
    - Latency counter loads RD_LAT; state goes to RD_WAIT.
  - Both amm_read_i and amm_write_i high: treated as a write; the read is discarded and no readdatavalid is produced.
- RD_WAIT:
  - amm_waitrequest_o=1; rf_addr_o is held.
  - Counter decrements each edge.
  - At edge E0+RD_LAT: rf_data_i is captured into amm_readdata_o and amm_readdatavalid_o=1 for one cycle. State returns to IDLE, so waitrequest=0 in that same cycle.
- Read latency: readdatavalid is high in the cycle after edge E0+RD_LAT. Read throughput is one per RD_LAT+1 cycles.
- Write followed immediately by a read to the same address: the read returns the newly written value. The register file updates at the write strobe edge, which precedes the read sampling edge.
- amm_readdata_o holds its last value when readdatavalid=0.
- Reset mid-read: the read is abandoned and no readdatavalid is produced. All outputs take their reset values immediately (asynchronous reset).
- rf_be_o=0 with a write: rf_wren_o still pulses; the register file changes nothing.

Optional Feature:
- Macro: AMM_RF_BRIDGE_ERR_EN.
- Defined:
  - The address is range-checked using the same decode as the register file.
    - SEL_SR_BY_MSB=1: valid if MSB=0 and low bits < CTRL_CNT, or MSB=1 and low bits < STAT_CNT.
    - SEL_SR_BY_MSB=0: valid if address < CTRL_CNT+STAT_CNT.
  - Invalid write: accepted, but rf_wren_o stays 0.
  - Invalid read: readdata=0, with normal timing.
  - amm_response_o=2'b10 (SLVERROR) alongside readdatavalid for an invalid read; 2'b00 otherwise.
- Undefined: no amm_response_o port; every address is forwarded unchecked.

Test Plan:
1. Reset release:
   - rst_i 1→0 → waitrequest=1 for one cycle, then 0.
   - All rf_* outputs are 0 until the first command.
2. Write then read, RD_LAT=1:
   - Write addr 3, data 0xA5A5_1234, be 4'b1111, then read addr 3 on the next cycle.
   - → rf_wren_o pulses once.
   - → readdatavalid two cycles after read acceptance, readdata=0xA5A5_1234.
3. Partial byte enable:
   - Write 0xFFFF_FFFF to addr 5, then write 0x0000_0000 with be 4'b0101, then read addr 5.
   - → 0xFF00_FF00.
4. Back-to-back and latency:
   - RD_LAT=3, four consecutive reads of addrs 64..67 with sreg=0x10..0x13.
   - → data 0x10..0x13 in order.
   - → reads accepted every 4 cycles; waitrequest high for 3 cycles after each acceptance.
5. Simultaneous read+write and reset mid-read:
   - read=write=1 to addr 2 with data 0x77 → write performed, no readdatavalid.
   - Assert rst_i one cycle into RD_WAIT → no readdatavalid; outputs at reset values.
6. AMM_RF_BRIDGE_ERR_EN defined, CTRL_CNT=32:
   - Write addr 40 → rf_wren_o stays 0.
   - Read addr 40 → readdata=0, response=2'b10.
   - Read addr 3 → response=2'b00.
